// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared FPU constants and 28-bit working mantissa field map
package fpu_pkg;

    localparam int BIAS       = 127;
    localparam int EXP_MAX    = 255;

    localparam int EXP_W      = 8;
    localparam int FRAC_W     = 23;
    localparam int MAN_W      = 24;

    localparam int IN_EXP_W   = 10;
    localparam int IN_MANT_W  = 28;
    localparam int NORM_W     = 27;
    localparam int WORK_EXP_W = 12;
    localparam int LZC_W      = 5;

    localparam int M_CARRY    = 27;
    localparam int M_HIDDEN   = 26;
    localparam int M_FRAC_HI  = 25;
    localparam int M_FRAC_LO  = 3;
    localparam int M_GUARD    = 2;
    localparam int M_ROUND    = 1;
    localparam int M_STICKY   = 0;

    // Sign-extend the biased input exponent into the wider working exponent
    // so that normalisation shifts and rounding carries cannot wrap.
    function automatic logic [WORK_EXP_W-1:0] widen_exp(input logic [IN_EXP_W-1:0] e);
        return {{(WORK_EXP_W - IN_EXP_W){e[IN_EXP_W-1]}}, e};
    endfunction

endpackage

// File: rtl/fpu_lzc.sv
// rtl/fpu_lzc.sv - combinational leading-zero count of a 27-bit mantissa
import fpu_pkg::*;

module fpu_lzc (
    input  logic [NORM_W-1:0] value,
    output logic [LZC_W-1:0]  count
);

    // Scan from LSB upwards so the highest set bit wins; all-zero yields 27.
    always_comb begin
        count = 5'd27;
        for (int i = 0; i < NORM_W; i++) begin
            if (value[i]) begin
                count = 5'(NORM_W - 1 - i);
            end
        end
    end

endmodule

// File: rtl/fpu_pack.sv
// rtl/fpu_pack.sv - two-stage normalise and round-to-nearest-even IEEE single packer
import fpu_pkg::*;

module fpu_pack (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_sign,
    input  logic [IN_EXP_W-1:0]  in_exponent,
    input  logic [IN_MANT_W-1:0] in_mantissa,
    input  logic [1:0]           in_operator,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_result,
    output logic [1:0]           out_operator,
    output logic                 out_overflow,
    output logic                 out_underflow,
    output logic                 out_inexact
);

    // Stage 1 registers: normalised mantissa has the hidden bit at [26]
    // (zero only for a zero result) with guard/round/sticky in [2:0].
    logic                  s1_valid;
    logic                  s1_sign;
    logic [WORK_EXP_W-1:0] s1_exp;
    logic [NORM_W-1:0]     s1_mant;
    logic [1:0]            s1_op;

    logic                  s2_ready;

    logic [LZC_W-1:0]      lz_count;
    logic [WORK_EXP_W-1:0] exp_ext;
    logic [NORM_W-1:0]     norm_mant;
    logic [WORK_EXP_W-1:0] norm_exp;

    logic                  round_up;
    logic                  inexact;
    logic [MAN_W-1:0]      frac_sum;
    logic [FRAC_W-1:0]     rnd_frac;
    logic [WORK_EXP_W-1:0] rnd_exp;
    logic                  nonzero;
    logic [31:0]           pack_result;
    logic                  pack_ovf;
    logic                  pack_unf;
    logic                  pack_inx;

    assign s2_ready = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_ready;
    assign exp_ext  = widen_exp(in_exponent);

    fpu_lzc u_lzc (
        .value (in_mantissa[M_HIDDEN:0]),
        .count (lz_count)
    );

    // Normalise: fold an adder carry back down, or shift the leading one up to the hidden position.
    always_comb begin
        norm_mant = '0;
        norm_exp  = '0;
        if (in_mantissa[M_CARRY]) begin
            norm_mant = {in_mantissa[M_CARRY:2], in_mantissa[1] | in_mantissa[0]};
            norm_exp  = exp_ext + 12'd1;
        end else if (in_mantissa[M_HIDDEN:0] != '0) begin
            norm_mant = in_mantissa[M_HIDDEN:0] << lz_count;
            norm_exp  = exp_ext - {7'd0, lz_count};
        end
    end

    // Stage 1 register advances whenever stage 2 can take its current contents.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_exp   <= '0;
            s1_mant  <= '0;
            s1_op    <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sign <= in_sign;
                s1_exp  <= norm_exp;
                s1_mant <= norm_mant;
                s1_op   <= in_operator;
            end
        end
    end

    // Round to nearest even on the normalised mantissa, then classify the exponent.
    always_comb begin
        nonzero  = s1_mant[M_HIDDEN];
        inexact  = s1_mant[M_GUARD] | s1_mant[M_ROUND] | s1_mant[M_STICKY];
        round_up = s1_mant[M_GUARD] &
                   (s1_mant[M_ROUND] | s1_mant[M_STICKY] | s1_mant[M_FRAC_LO]);
        frac_sum = {1'b0, s1_mant[M_FRAC_HI:M_FRAC_LO]} + {23'd0, round_up};
        rnd_frac = frac_sum[FRAC_W-1:0];
        rnd_exp  = s1_exp + {11'd0, frac_sum[FRAC_W]};

        pack_result = {s1_sign, rnd_exp[EXP_W-1:0], rnd_frac};
        pack_ovf    = 1'b0;
        pack_unf    = 1'b0;
        pack_inx    = inexact;
        if (!nonzero) begin
            pack_result = {s1_sign, 31'h0};
            pack_inx    = 1'b0;
        end else if ($signed(rnd_exp) >= 12'sd255) begin
            pack_result = {s1_sign, 8'hFF, 23'h0};
            pack_ovf    = 1'b1;
            pack_inx    = 1'b1;
        end else if ($signed(rnd_exp) <= 12'sd0) begin
            pack_result = {s1_sign, 31'h0};
            pack_unf    = 1'b1;
            pack_inx    = 1'b1;
        end
    end

    // Stage 2 / output register holds its result until the consumer takes it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid     <= 1'b0;
            out_result    <= '0;
            out_operator  <= '0;
            out_overflow  <= 1'b0;
            out_underflow <= 1'b0;
            out_inexact   <= 1'b0;
        end else if (s2_ready) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_result    <= pack_result;
                out_operator  <= s1_op;
                out_overflow  <= pack_ovf;
                out_underflow <= pack_unf;
                out_inexact   <= pack_inx;
            end
        end
    end

endmodule

// File: tb/tb_fpu_pack.sv
// tb/tb_fpu_pack.sv - directed self-checking bench for fpu_pack
module tb_fpu_pack;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [9:0]  in_exponent;
    logic [27:0] in_mantissa;
    logic [1:0]  in_operator;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [1:0]  out_operator;
    logic        out_overflow;
    logic        out_underflow;
    logic        out_inexact;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fpu_pack dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_sign       (in_sign),
        .in_exponent   (in_exponent),
        .in_mantissa   (in_mantissa),
        .in_operator   (in_operator),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_result    (out_result),
        .out_operator  (out_operator),
        .out_overflow  (out_overflow),
        .out_underflow (out_underflow),
        .out_inexact   (out_inexact)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got=%h want=%h", tag, got, want);
        end
    endtask

    // One isolated transaction; flags = {overflow, underflow, inexact}.
    task automatic send_one(input string tag, input logic sgn, input logic [9:0] e,
                            input logic [27:0] m, input logic [1:0] op,
                            input logic [31:0] want, input logic [2:0] flags);
        @(negedge clk);
        in_valid    = 1'b1;
        in_sign     = sgn;
        in_exponent = e;
        in_mantissa = m;
        in_operator = op;
        out_ready   = 1'b1;
        #1;
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check({tag, "_early_valid"}, 32'(out_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_result"}, out_result, want);
        check({tag, "_flags"}, 32'({out_overflow, out_underflow, out_inexact}), 32'(flags));
        check({tag, "_op"}, 32'(out_operator), 32'(op));
    endtask

    initial begin
        int  sent;
        int  rcvd;
        int  cyc;
        bit  stall_seen;
        bit  acc_in;
        bit  acc_out;
        bit  stale_seen;

        reset       = 1'b1;
        in_valid    = 1'b0;
        in_sign     = 1'b0;
        in_exponent = '0;
        in_mantissa = '0;
        in_operator = '0;
        out_ready   = 1'b0;

        repeat (2) @(negedge clk);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_result", out_result, 32'h0);
        check("reset_flags", 32'({out_overflow, out_underflow, out_inexact, out_operator}), 32'd0);
        reset = 1'b0;
        #1;
        check("reset_in_ready", 32'(in_ready), 32'd1);

        send_one("one",        1'b0, 10'd127, 28'h4000000, 2'd1, 32'h3F800000, 3'b000);
        send_one("carry",      1'b0, 10'd127, 28'h8000000, 2'd2, 32'h40000000, 3'b000);
        send_one("carry_stk",  1'b0, 10'd127, 28'h8000001, 2'd3, 32'h40000000, 3'b001);
        send_one("lshift2",    1'b0, 10'd127, 28'h1000000, 2'd0, 32'h3E800000, 3'b000);
        send_one("tie_even",   1'b0, 10'd127, 28'h4000004, 2'd1, 32'h3F800000, 3'b001);
        send_one("tie_odd",    1'b0, 10'd127, 28'h400000C, 2'd2, 32'h3F800002, 3'b001);
        send_one("rnd_ovf",    1'b0, 10'd254, 28'h7FFFFFF, 2'd3, 32'h7F800000, 3'b101);
        send_one("max_norm",   1'b1, 10'd254, 28'h4000000, 2'd0, 32'hFF000000, 3'b000);
        send_one("exp_ovf",    1'b0, 10'd255, 28'h4000000, 2'd1, 32'h7F800000, 3'b101);
        send_one("exp0_unf",   1'b0, 10'd0,   28'h4000000, 2'd2, 32'h00000000, 3'b011);
        send_one("shift_unf",  1'b1, 10'd1,   28'h2000000, 2'd3, 32'h80000000, 3'b011);
        send_one("neg_zero",   1'b1, 10'd127, 28'h0000000, 2'd0, 32'h80000000, 3'b000);
        send_one("min_norm",   1'b0, 10'd1,   28'h4000000, 2'd1, 32'h00800000, 3'b000);

        sent       = 0;
        rcvd       = 0;
        cyc        = 0;
        stall_seen = 1'b0;
        while (rcvd < 8 && cyc < 200) begin
            @(negedge clk);
            in_valid    = (sent < 8);
            in_sign     = 1'b0;
            in_exponent = 10'(127 + sent);
            in_mantissa = 28'h4000000;
            in_operator = 2'(sent);
            out_ready   = (cyc % 3 == 0);
            #1;
            if (in_valid && !in_ready) stall_seen = 1'b1;
            acc_in  = in_valid && in_ready;
            acc_out = out_valid && out_ready;
            if (acc_out) begin
                check($sformatf("stream_res%0d", rcvd), out_result, {1'b0, 8'(127 + rcvd), 23'd0});
                check($sformatf("stream_op%0d", rcvd), 32'(out_operator), 32'(rcvd % 4));
                rcvd++;
            end
            @(posedge clk);
            if (acc_in) sent++;
            cyc++;
        end
        in_valid = 1'b0;
        check("stream_count", 32'(rcvd), 32'd8);
        check("stream_stall", 32'(stall_seen), 32'd1);

        @(negedge clk);
        out_ready   = 1'b0;
        in_valid    = 1'b1;
        in_exponent = 10'd130;
        in_mantissa = 28'h4000000;
        @(negedge clk);
        in_exponent = 10'd131;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("full_out_valid", 32'(out_valid), 32'd1);
        check("full_in_ready", 32'(in_ready), 32'd0);
        #1;
        reset = 1'b1;
        #1;
        check("rst_async_valid", 32'(out_valid), 32'd0);
        check("rst_async_result", out_result, 32'h0);
        @(negedge clk);
        reset     = 1'b0;
        out_ready = 1'b1;
        #1;
        check("rst_release_ready", 32'(in_ready), 32'd1);
        stale_seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (out_valid) stale_seen = 1'b1;
        end
        check("rst_no_stale", 32'(stale_seen), 32'd0);
        send_one("post_rst", 1'b0, 10'd128, 28'h6000000, 2'd2, 32'h40400000, 3'b000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
